// File: rtl/uart_frame_loader_pkg.sv
// rtl/uart_frame_loader_pkg.sv - shared constants, loader states and helpers for uart_frame_loader
package uart_frame_loader_pkg;

    localparam int ETH_AW      = 11;
    localparam int ETH_MIN_LEN = 60;
    localparam int ETH_MAX_LEN = 1514;

    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_SP    = 8'h20;
    localparam logic [7:0] CHAR_TAB   = 8'h09;
    localparam logic [7:0] CHAR_COLON = 8'h3A;
    localparam logic [7:0] CHAR_DASH  = 8'h2D;

    typedef logic [2:0] loader_state_t;

    localparam loader_state_t ST_COLLECT = 3'd0;
    localparam loader_state_t ST_DISCARD = 3'd1;
    localparam loader_state_t ST_LAUNCH  = 3'd2;
    localparam loader_state_t ST_WAIT_HI = 3'd3;
    localparam loader_state_t ST_WAIT_LO = 3'd4;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/uart_frame_loader_if.sv
// rtl/uart_frame_loader_if.sv - MAC transmit-side bus between loader (master) and MAC (slave)
interface uart_frame_loader_if #(
    parameter int AW = 11
);
    logic          tx_vld;
    logic [AW-1:0] tx_count;
    logic [AW-1:0] tx_addr;
    logic [7:0]    tx_data;
    logic          tx_busy;

    modport master (
        output tx_vld,
        output tx_count,
        output tx_data,
        input  tx_addr,
        input  tx_busy
    );

    modport slave (
        input  tx_vld,
        input  tx_count,
        input  tx_data,
        output tx_addr,
        output tx_busy
    );
endinterface

// File: rtl/uart_frame_loader_char2nib.sv
// rtl/uart_frame_loader_char2nib.sv - classifies an ASCII character and decodes hex digits to a nibble
module uart_frame_loader_char2nib
    import uart_frame_loader_pkg::*;
(
    input  logic [7:0] ch_i,
    output logic       is_hex_o,
    output logic       is_skip_o,
    output logic       is_eol_o,
    output logic [3:0] nib_o
);

    always_comb begin
        is_hex_o  = 1'b0;
        is_skip_o = 1'b0;
        is_eol_o  = 1'b0;
        nib_o     = 4'h0;
        if (ch_i >= 8'h30 && ch_i <= 8'h39) begin
            is_hex_o = 1'b1;
            nib_o    = ch_i[3:0];
        end else if ((ch_i >= 8'h41 && ch_i <= 8'h46) || (ch_i >= 8'h61 && ch_i <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 lands on 0xA
            is_hex_o = 1'b1;
            nib_o    = ch_i[3:0] + 4'd9;
        end else if (ch_i == CHAR_SP || ch_i == CHAR_TAB || ch_i == CHAR_COLON || ch_i == CHAR_DASH) begin
            is_skip_o = 1'b1;
        end else if (ch_i == CHAR_LF || ch_i == CHAR_CR) begin
            is_eol_o = 1'b1;
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// rtl/uart_frame_loader.sv - ASCII-hex UART lines to Ethernet frames for the MAC TX port.
// Optional character echo enabled by defining UART_FRAME_LOADER_ECHO_EN.
module uart_frame_loader
    import uart_frame_loader_pkg::*;
#(
    parameter int MAX_LEN = ETH_MAX_LEN,
    parameter int MIN_LEN = ETH_MIN_LEN,
    parameter int AW      = ETH_AW
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_vld,
    input  logic [7:0]          rx_data,
    uart_frame_loader_if.master tx,
    output logic [15:0]         frame_cnt,
    output logic [15:0]         err_cnt
`ifdef UART_FRAME_LOADER_ECHO_EN
    ,
    output logic                echo_vld,
    output logic [7:0]          echo_data
`endif
);

    localparam logic [AW-1:0] MAX_LEN_W = AW'(MAX_LEN);
    localparam logic [AW-1:0] MIN_LEN_W = AW'(MIN_LEN);

    logic       is_hex, is_skip, is_eol;
    logic [3:0] nib;

    uart_frame_loader_char2nib u_char2nib (
        .ch_i      (rx_data),
        .is_hex_o  (is_hex),
        .is_skip_o (is_skip),
        .is_eol_o  (is_eol),
        .nib_o     (nib)
    );

    loader_state_t state_q, state_d;
    logic [AW-1:0] count_q, count_d;
    logic          nib_flag_q, nib_flag_d;
    logic [3:0]    hi_q, hi_d;
    logic [AW-1:0] tx_count_q, tx_count_d;
    logic          tx_vld_q, tx_vld_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [15:0]   err_cnt_q, err_cnt_d;
    logic          wr_en;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        nib_flag_d  = nib_flag_q;
        hi_d        = hi_q;
        tx_count_d  = tx_count_q;
        tx_vld_d    = 1'b0;
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        wr_en       = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (rx_vld) begin
                    if (is_hex) begin
                        if (!nib_flag_q) begin
                            hi_d       = nib;
                            nib_flag_d = 1'b1;
                        end else if (count_q == MAX_LEN_W) begin
                            nib_flag_d = 1'b0;
                            state_d    = ST_DISCARD;
                        end else begin
                            wr_en      = 1'b1;
                            count_d    = count_q + AW'(1);
                            nib_flag_d = 1'b0;
                        end
                    end else if (is_eol) begin
                        if (nib_flag_q) begin
                            err_cnt_d  = sat_inc(err_cnt_q);
                            count_d    = '0;
                            nib_flag_d = 1'b0;
                        end else if (count_q != '0) begin
                            tx_count_d = (count_q < MIN_LEN_W) ? MIN_LEN_W : count_q;
                            state_d    = ST_LAUNCH;
                        end
                    end else if (!is_skip) begin
                        state_d = ST_DISCARD;
                    end
                end
            end
            ST_DISCARD: begin
                if (rx_vld && is_eol) begin
                    err_cnt_d  = sat_inc(err_cnt_q);
                    count_d    = '0;
                    nib_flag_d = 1'b0;
                    state_d    = ST_COLLECT;
                end
            end
            ST_LAUNCH: begin
                if (!tx.tx_busy) begin
                    tx_vld_d    = 1'b1;
                    frame_cnt_d = sat_inc(frame_cnt_q);
                    state_d     = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (tx.tx_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!tx.tx_busy) begin
                    count_d    = '0;
                    nib_flag_d = 1'b0;
                    state_d    = ST_COLLECT;
                end
            end
            default: begin
                count_d    = '0;
                nib_flag_d = 1'b0;
                state_d    = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_COLLECT;
            count_q     <= '0;
            nib_flag_q  <= 1'b0;
            hi_q        <= 4'h0;
            tx_count_q  <= '0;
            tx_vld_q    <= 1'b0;
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 16'h0000;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            nib_flag_q  <= nib_flag_d;
            hi_q        <= hi_d;
            tx_count_q  <= tx_count_d;
            tx_vld_q    <= tx_vld_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Frame buffer: RAM array without reset; the range flag alone supplies zero padding.
    logic [7:0] buf_mem [0:(1<<AW)-1];
    logic [7:0] rd_data_q;
    logic       rd_in_range_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_mem[count_q] <= {hi_q, nib};
        end
        rd_data_q <= buf_mem[tx.tx_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_in_range_q <= 1'b0;
        end else begin
            rd_in_range_q <= (tx.tx_addr < count_q);
        end
    end

    assign tx.tx_data  = rd_in_range_q ? rd_data_q : 8'h00;
    assign tx.tx_vld   = tx_vld_q;
    assign tx.tx_count = tx_count_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

`ifdef UART_FRAME_LOADER_ECHO_EN
    logic       echo_vld_q;
    logic [7:0] echo_data_q;
    logic       echo_lf_q;
    logic       echo_take;

    assign echo_take = rx_vld && (state_q == ST_COLLECT || state_q == ST_DISCARD);

    // An EOL becomes CR now and LF on the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            echo_vld_q  <= 1'b0;
            echo_data_q <= 8'h00;
            echo_lf_q   <= 1'b0;
        end else begin
            echo_lf_q <= echo_take && is_eol;
            if (echo_lf_q) begin
                echo_vld_q  <= 1'b1;
                echo_data_q <= CHAR_LF;
            end else if (echo_take) begin
                echo_vld_q  <= 1'b1;
                echo_data_q <= is_eol ? CHAR_CR : rx_data;
            end else begin
                echo_vld_q  <= 1'b0;
            end
        end
    end

    assign echo_vld  = echo_vld_q;
    assign echo_data = echo_data_q;
`endif

endmodule

// File: tb/tb_uart_frame_loader.sv
// tb/tb_uart_frame_loader.sv - directed self-checking bench for uart_frame_loader
module tb_uart_frame_loader;
    import uart_frame_loader_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_vld;
    logic [7:0]  rx_data;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
`ifdef UART_FRAME_LOADER_ECHO_EN
    logic        echo_vld;
    logic [7:0]  echo_data;
`endif

    uart_frame_loader_if #(.AW(11)) tx_if ();

    uart_frame_loader dut (
        .clk       (clk),
        .reset     (reset),
        .rx_vld    (rx_vld),
        .rx_data   (rx_data),
        .tx        (tx_if),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
`ifdef UART_FRAME_LOADER_ECHO_EN
        ,
        .echo_vld  (echo_vld),
        .echo_data (echo_data)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int vld_seen = 0;
    logic [7:0] exp_buf [0:2047];

    always @(posedge clk) if (tx_if.tx_vld === 1'b1) vld_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_char(input logic [7:0] c);
        rx_data = c;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i]);
    endtask

    task automatic send_hex(input int n, input string eol);
        for (int i = 0; i < n; i++) send_str($sformatf("%02x", exp_buf[i]));
        send_str(eol);
    endtask

    task automatic wait_launch(input string tag, input int base);
        int t = 0;
        while (vld_seen == base && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_launch"}, vld_seen, base + 1);
    endtask

    // MAC side: raise busy, read n_read addresses, then release the loader.
    task automatic read_frame(input string tag, input int data_len, input int exp_count, input int n_read);
        int bad = 0;
        logic [7:0] want;
        check({tag, "_count"}, 32'(tx_if.tx_count), exp_count);
        tx_if.tx_busy = 1'b1;
        for (int a = 0; a < n_read; a++) begin
            tx_if.tx_addr = 11'(a);
            @(negedge clk);
            want = (a < data_len) ? exp_buf[a] : 8'h00;
            if (tx_if.tx_data !== want) bad++;
        end
        check({tag, "_data_errs"}, bad, 0);
        tx_if.tx_busy = 1'b0;
        tx_if.tx_addr = '0;
        tick(4);
    endtask

    initial begin
        int base;
        int exp_frames;
        int exp_errs;
        string s;
        logic [7:0] t1 [0:13];

        reset         = 1'b1;
        rx_vld        = 1'b0;
        rx_data       = 8'h00;
        tx_if.tx_busy = 1'b0;
        tx_if.tx_addr = '0;
        exp_frames    = 0;
        exp_errs      = 0;
        tick(3);
        reset = 1'b0;
        tick(1);
        check("rst_tx_vld", 32'(tx_if.tx_vld), 0);
        check("rst_tx_count", 32'(tx_if.tx_count), 0);
        check("rst_tx_data", 32'(tx_if.tx_data), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);

        // Separators inside a line, CRLF terminated, 60 bytes
        exp_buf[0] = 8'h0A; exp_buf[1] = 8'h0B; exp_buf[2] = 8'h0C; exp_buf[3] = 8'h0D;
        s = "0A:0b-0C 0d";
        for (int i = 4; i < 60; i++) begin
            exp_buf[i] = 8'(i);
            s = {s, $sformatf(" %02X", i)};
        end
        s = {s, "\r\n"};
        base = vld_seen;
        send_str(s);
        wait_launch("sep", base);
        read_frame("sep", 60, 60, 64);
        exp_frames++;
        tick(20);
        check("sep_single_launch", vld_seen, base + 1);
        check("sep_frame_cnt", 32'(frame_cnt), exp_frames);
        check("sep_err_cnt", 32'(err_cnt), exp_errs);

        // Short frame padded to 60 over stale buffer contents
        t1 = '{8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'hff, 8'h00, 8'h11,
               8'h22, 8'h33, 8'h44, 8'h55, 8'h08, 8'h06};
        for (int i = 0; i < 14; i++) exp_buf[i] = t1[i];
        base = vld_seen;
        send_str("ffffffffffff0011223344550806\n");
        wait_launch("short", base);
        read_frame("short", 14, 60, 60);
        exp_frames++;
        check("short_frame_cnt", 32'(frame_cnt), exp_frames);

        // Bad character discards the line
        base = vld_seen;
        send_str("12G4\n");
        tick(10);
        exp_errs++;
        check("bad_no_launch", vld_seen, base);
        check("bad_err_cnt", 32'(err_cnt), exp_errs);
        for (int i = 0; i < 60; i++) exp_buf[i] = (i % 2 == 0) ? 8'hab : 8'hcd;
        send_hex(60, "\n");
        wait_launch("abcd", base);
        read_frame("abcd", 60, 60, 62);
        exp_frames++;
        check("abcd_frame_cnt", 32'(frame_cnt), exp_frames);

        // Odd nibble count, then blank lines
        base = vld_seen;
        send_str("123\n");
        tick(10);
        exp_errs++;
        check("odd_no_launch", vld_seen, base);
        check("odd_err_cnt", 32'(err_cnt), exp_errs);
        send_str("\r\n\r\n");
        tick(10);
        check("blank_no_launch", vld_seen, base);
        check("blank_err_cnt", 32'(err_cnt), exp_errs);

        // Overflow at 1515 bytes, then exactly MAX_LEN
        for (int i = 0; i < 1515; i++) exp_buf[i] = 8'(i * 7 + 3);
        send_hex(1515, "\n");
        tick(10);
        exp_errs++;
        check("ovf_no_launch", vld_seen, base);
        check("ovf_err_cnt", 32'(err_cnt), exp_errs);
        send_hex(1514, "\n");
        wait_launch("max", base);
        read_frame("max", 1514, 1514, 1520);
        exp_frames++;
        check("max_frame_cnt", 32'(frame_cnt), exp_frames);

        // MAC busy before EOL holds the launch; chars during WAIT_LO are dropped
        tx_if.tx_busy = 1'b1;
        for (int i = 0; i < 20; i++) exp_buf[i] = 8'(8'h40 + i);
        base = vld_seen;
        send_hex(20, "\n");
        tick(20);
        check("busy_held", vld_seen, base);
        tx_if.tx_busy = 1'b0;
        wait_launch("busy", base);
        exp_frames++;
        check("busy_count", 32'(tx_if.tx_count), 60);
        tx_if.tx_busy = 1'b1;
        tick(2);
        send_str("ff\nzz\n");
        tick(5);
        check("wlo_no_launch", vld_seen, base + 1);
        check("wlo_err_cnt", 32'(err_cnt), exp_errs);
        tx_if.tx_busy = 1'b0;
        tick(4);
        exp_buf[0] = 8'hbe;
        exp_buf[1] = 8'hef;
        base = vld_seen;
        send_str("beef\n");
        wait_launch("after", base);
        read_frame("after", 2, 60, 8);
        exp_frames++;
        check("after_frame_cnt", 32'(frame_cnt), exp_frames);

        // Reset mid-line drops the partial line and clears counters
        send_str("1234");
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
        check("mid_rst_tx_vld", 32'(tx_if.tx_vld), 0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
        check("mid_rst_err_cnt", 32'(err_cnt), 0);
        check("mid_rst_tx_count", 32'(tx_if.tx_count), 0);
        exp_buf[0] = 8'h56;
        base = vld_seen;
        send_str("56\n");
        wait_launch("post_rst", base);
        read_frame("post_rst", 1, 60, 4);
        check("post_rst_frame_cnt", 32'(frame_cnt), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_frame_loader.md
Name: uart_frame_loader

Overview:
Converts ASCII-hex lines received on the UART into raw Ethernet frames and hands them to the eth MAC TX port. It sits between the uart RX output and the eth tx_* interface, so the board can inject arbitrary test frames from a terminal. It is the upstream counterpart of the TX-side bin2char path. It holds one frame in an internal byte buffer that the MAC reads by address.

Parameters:
MAX_LEN, 1514, maximum frame bytes accepted, excluding FCS; must be ≤ 2047.
MIN_LEN, 60, minimum transmitted length; shorter frames are zero-padded on read.
AW, 11, buffer/address width; matches eth tx_addr/tx_count.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
rx_vld  in  1  one-cycle strobe: rx_data holds a received UART character
rx_data  in  8  ASCII character
tx_vld  out  1  one-cycle launch request to MAC
tx_count  out  AW  frame length in bytes, stable while tx_vld/tx_busy
tx_addr  in  AW  byte address driven by MAC
tx_data  out  8  buffer byte at tx_addr, registered (1-cycle read latency)
tx_busy  in  1  MAC transmitting
frame_cnt  out  16  frames launched, saturating
err_cnt  out  16  lines rejected, saturating

Behaviour:
- Reset values: tx_vld=0, tx_count=0, tx_data=0, frame_cnt=0, err_cnt=0; state=COLLECT; byte count=0; nibble flag=0. Buffer contents are not reset.
- Character classes:
  - HEX: 0-9, a-f, A-F.
  - SKIP: space, tab, ':', '-'.
  - EOL: 0x0A or 0x0D.
  - Anything else is BAD.
- COLLECT:
  - HEX with nibble flag=0: store the high nibble, set the flag.
  - HEX with nibble flag=1: write {hi, lo} to buf[count], count++, clear the flag.
  - SKIP is ignored, and does not split a byte.
  - BAD → go to DISCARD.
  - A byte write at count==MAX_LEN → DISCARD (overflow).
- EOL in COLLECT:
  - count==0 and nibble flag=0 → ignored (blank line, CR/LF pairs).
  - nibble flag=1 → err_cnt++, reset line state, stay in COLLECT.
  - Otherwise → tx_count=max(count, MIN_LEN), go to LAUNCH.
- DISCARD: ignores all characters until EOL. At that EOL: err_cnt++, count=0, flag=0, go to COLLECT.
- LAUNCH:
  - When tx_busy=0, assert tx_vld for exactly one cycle, frame_cnt++, go to WAIT_HI.
  - If tx_busy=1, hold in LAUNCH with tx_vld low.
- WAIT_HI: wait until tx_busy=1, then go to WAIT_LO.
- WAIT_LO: wait until tx_busy=0, then count=0, flag=0, go to COLLECT.
- Characters received in LAUNCH/WAIT_HI/WAIT_LO are dropped. An EOL dropped there does not touch err_cnt, and the buffer is never written while a frame is in flight.
- Read port: tx_data <= (tx_addr < count) ? buf[tx_addr] : 8'h00, registered every cycle regardless of state. Addresses ≥ count read as zero, which provides padding.
- Counters saturate at 16'hFFFF.
- rx_vld coincident with a state transition is processed by the current state only.
- Reset mid-frame: returns to COLLECT, tx_vld low next cycle, partial line lost.

Optional Feature:
UART_FRAME_LOADER_ECHO_EN
- Defined: adds outputs echo_vld (1) and echo_data (8), a registered copy of each accepted character, one cycle after rx_vld. Characters are not echoed while in LAUNCH/WAIT_*. An EOL in COLLECT/DISCARD is echoed as 0x0D then 0x0A on consecutive cycles. The consumer must tolerate back-to-back strobes, typically via minififo.
- Undefined: the ports are absent and no echo logic is built.

Decomposition:
- Shared package eth_pkg:
  - ETH_AW=11
  - ETH_MIN_LEN=60
  - ETH_MAX_LEN=1514
  - ASCII constants (CHAR_LF, CHAR_CR, CHAR_SP)
  - loader state enum typedef {COLLECT, DISCARD, LAUNCH, WAIT_HI, WAIT_LO}
- Natural sub-module: char2nib (combinational classify plus hex→nibble: outputs is_hex, is_skip, is_eol, nib[3:0]); mirror of bin2char.
- Buffer: inferred simple dual-port RAM inside the top module.

Test Plan:
- "ffffffffffff0011223344550806\n" (14 bytes) → one tx_vld; tx_count=60; addr 0..13 match the input bytes; addr 14..59 read 0x00; frame_cnt=1.
- "0A:0b-0C 0d\r\n" with 60 bytes total on the line → tx_count=60; bytes 00..03 = 0A 0B 0C 0D; the CRLF produces a single launch; err_cnt=0.
- "12G4\n" → no tx_vld, err_cnt=1; next line "abcd…" (60 bytes) launches normally.
- "123\n" (odd nibble count) → err_cnt=1, no launch; blank "\r\n\r\n" → no change.
- 1515 valid bytes then "\n" → DISCARD, err_cnt=1, no launch; exactly 1514 bytes → tx_count=1514.
- tx_busy held high before EOL → tx_vld waits until tx_busy=0; characters sent during WAIT_LO are dropped; the following line launches frame_cnt=2.
